// File: rtl/alu_issue_stage_if.sv
// Handshake and ALU-operand bundle between the instruction source,
// the issue stage and the ALU that consumes its head entry.
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  op;
    logic        ovf_en;
    logic        illegal;

    // Producer/consumer side: supplies instructions, flush and out_ready.
    modport master (
        output in_valid, instr, rs_val, rt_val, flush, out_ready,
        input  in_ready, out_valid, x, y, op, ovf_en, illegal
    );

    // Issue stage side.
    modport slave (
        input  in_valid, instr, rs_val, rt_val, flush, out_ready,
        output in_ready, out_valid, x, y, op, ovf_en, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a MIPS-format instruction into ALU op/operands
// and buffers up to two decoded entries in a head/tail skid FIFO.
// The outputs come straight from the head register, so the path from
// in_* to out_* is always registered.
module alu_issue_stage (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_SLT  = 3'b011,
        OP_SRL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_SLL  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    // One buffered entry: 32 + 32 + 3 + 1 + 1 = 69 bits.
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        alu_op_e     op;
        logic        ovf_en;
        logic        illegal;
    } entry_t;

    localparam entry_t ILLEGAL_ENTRY = '{x: 32'd0, y: 32'd0, op: OP_RSVD,
                                         ovf_en: 1'b0, illegal: 1'b1};

    function automatic entry_t make_entry(input alu_op_e     op,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        ovf_en);
        return '{x: x, y: y, op: op, ovf_en: ovf_en, illegal: 1'b0};
    endfunction

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] sh_amt;
    logic [31:0] var_amt;
    entry_t      dec;

    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        push;
    logic        pop;

    assign opcode   = bus.instr[31:26];
    assign funct    = bus.instr[5:0];
    assign imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zext = {16'd0, bus.instr[15:0]};
    assign sh_amt   = {27'd0, bus.instr[10:6]};
    assign var_amt  = {27'd0, bus.rs_val[4:0]};

    // Combinational decode of the incoming instruction word.
    always_comb begin
        // NOTE: default assigned first so every path drives dec and no latch is inferred.
        dec = ILLEGAL_ENTRY;
        if (opcode == 6'h00) begin
            case (funct)
                6'h24:   dec = make_entry(OP_AND, bus.rs_val, bus.rt_val, 1'b0);
                6'h20:   dec = make_entry(OP_ADD, bus.rs_val, bus.rt_val, 1'b1);
                6'h21:   dec = make_entry(OP_ADD, bus.rs_val, bus.rt_val, 1'b0);
                6'h22:   dec = make_entry(OP_SUB, bus.rs_val, bus.rt_val, 1'b1);
                6'h23:   dec = make_entry(OP_SUB, bus.rs_val, bus.rt_val, 1'b0);
                6'h2a:   dec = make_entry(OP_SLT, bus.rs_val, bus.rt_val, 1'b0);
                6'h00:   dec = make_entry(OP_SLL, bus.rt_val, sh_amt, 1'b0);
                6'h02:   dec = make_entry(OP_SRL, bus.rt_val, sh_amt, 1'b0);
                6'h03:   dec = make_entry(OP_SRA, bus.rt_val, sh_amt, 1'b0);
                6'h04:   dec = make_entry(OP_SLL, bus.rt_val, var_amt, 1'b0);
                6'h06:   dec = make_entry(OP_SRL, bus.rt_val, var_amt, 1'b0);
                6'h07:   dec = make_entry(OP_SRA, bus.rt_val, var_amt, 1'b0);
                default: dec = ILLEGAL_ENTRY;
            endcase
        end else begin
            case (opcode)
                6'h08:   dec = make_entry(OP_ADD, bus.rs_val, imm_sext, 1'b1);
                6'h0c:   dec = make_entry(OP_AND, bus.rs_val, imm_zext, 1'b0);
                6'h0a:   dec = make_entry(OP_SLT, bus.rs_val, imm_sext, 1'b0);
                6'h04,
                6'h05:   dec = make_entry(OP_SUB, bus.rs_val, bus.rt_val, 1'b0);
                6'h23,
                6'h2b:   dec = make_entry(OP_ADD, bus.rs_val, imm_sext, 1'b0);
                default: dec = ILLEGAL_ENTRY;
            endcase
        end
    end

    assign bus.in_ready  = (count_q < 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Next-state of the two-entry FIFO; flush wins over push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = dec;
                    else                 tail_d = dec;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Only reachable at count 1: the new entry replaces the head.
                2'b11:   head_d = dec;
                default: ;
            endcase
        end
    end

    // State registers; reset clears entries so outputs read zero at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: both entry registers are reset because x/y/op are visible even when out_valid=0.
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.x       = head_q.x;
    assign bus.y       = head_q.y;
    assign bus.op      = head_q.op;
    assign bus.ovf_en  = head_q.ovf_en;
    assign bus.illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases plus random traffic,
// checked against a mnemonic-level reference decoder and a queue model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  op;
        logic        ovf_en;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [5:0] R_FN [12] = '{6'h24, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2a,
                                         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    localparam logic [5:0] I_OP [7]  = '{6'h08, 6'h0c, 6'h0a, 6'h04, 6'h05, 6'h23, 6'h2b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: name the instruction first, then apply its semantics.
    function automatic string mnemonic(input logic [31:0] instr);
        if (instr[31:26] == 6'h00) begin
            case (instr[5:0])
                6'h24: return "and";
                6'h20: return "add";
                6'h21: return "addu";
                6'h22: return "sub";
                6'h23: return "subu";
                6'h2a: return "slt";
                6'h00: return "sll";
                6'h02: return "srl";
                6'h03: return "sra";
                6'h04: return "sllv";
                6'h06: return "srlv";
                6'h07: return "srav";
                default: return "bad";
            endcase
        end
        case (instr[31:26])
            6'h08: return "addi";
            6'h0c: return "andi";
            6'h0a: return "slti";
            6'h04: return "beq";
            6'h05: return "bne";
            6'h23: return "lw";
            6'h2b: return "sw";
            default: return "bad";
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] instr,
                                        input logic [31:0] rs,
                                        input logic [31:0] rt);
        string       m;
        logic [31:0] imm_u;
        logic [31:0] imm_s;
        exp_t        e;
        m     = mnemonic(instr);
        imm_u = 32'(instr[15:0]);
        imm_s = instr[15] ? imm_u - 32'h0001_0000 : imm_u;
        e.x       = rs;
        e.y       = rt;
        e.illegal = (m == "bad");
        e.ovf_en  = (m == "add") || (m == "sub") || (m == "addi");
        if      (m == "and"  || m == "andi")                                e.op = 3'd0;
        else if (m == "add"  || m == "addu" || m == "addi" || m == "lw" || m == "sw") e.op = 3'd1;
        else if (m == "sub"  || m == "subu" || m == "beq"  || m == "bne")   e.op = 3'd2;
        else if (m == "slt"  || m == "slti")                                e.op = 3'd3;
        else if (m == "srl"  || m == "srlv")                                e.op = 3'd4;
        else if (m == "sra"  || m == "srav")                                e.op = 3'd5;
        else if (m == "sll"  || m == "sllv")                                e.op = 3'd6;
        else                                                                e.op = 3'd7;
        if (m == "addi" || m == "slti" || m == "lw" || m == "sw") e.y = imm_s;
        if (m == "andi") e.y = imm_u;
        if (m == "sll" || m == "srl" || m == "sra") begin
            e.x = rt;
            e.y = 32'(instr[10:6]);
        end
        if (m == "sllv" || m == "srlv" || m == "srav") begin
            e.x = rt;
            e.y = rs % 32;
        end
        if (e.illegal) begin
            e.x = 32'd0;
            e.y = 32'd0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 20);
        if (k < 12)       w = {6'h00, w[25:6], R_FN[k]};
        else if (k < 19)  w = {I_OP[k - 12], w[25:0]};
        else if (k == 19) w = {6'h00, w[25:6], 6'h3f};
        return w;
    endfunction

    // Issue side of the scoreboard: record every accepted instruction.
    always @(negedge clk) begin
        #1;
        if (rst || bus.flush) sb_q.delete();
        else if (bus.in_valid && bus.in_ready)
            sb_q.push_back(ref_decode(bus.instr, bus.rs_val, bus.rt_val));
    end

    // Monitor: compare the presented head and flow-control against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(bus.out_valid), 32'(sb_q.size() > 0));
            check("in_ready",  32'(bus.in_ready),  32'(sb_q.size() < 2));
            if (bus.out_valid && sb_q.size() > 0) begin
                check("x",       bus.x,                sb_q[0].x);
                check("y",       bus.y,                sb_q[0].y);
                check("op",      32'(bus.op),          32'(sb_q[0].op));
                check("ovf_en",  32'(bus.ovf_en),      32'(sb_q[0].ovf_en));
                check("illegal", 32'(bus.illegal),     32'(sb_q[0].illegal));
                if (bus.out_ready && !bus.flush) void'(sb_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = 1'b1;
        bus.instr    = i;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [31:0] ex, input logic [31:0] ey,
                              input logic [2:0] eop, input logic eovf, input logic eill);
        check({name, "_valid"},   32'(bus.out_valid), 32'd1);
        check({name, "_x"},       bus.x,              ex);
        check({name, "_y"},       bus.y,              ey);
        check({name, "_op"},      32'(bus.op),        32'(eop));
        check({name, "_ovf_en"},  32'(bus.ovf_en),    32'(eovf));
        check({name, "_illegal"}, 32'(bus.illegal),   32'(eill));
    endtask

    task automatic check_empty_zero(input string name);
        check({name, "_x"},         bus.x,              32'd0);
        check({name, "_y"},         bus.y,              32'd0);
        check({name, "_op"},        32'(bus.op),        32'd0);
        check({name, "_ovf_en"},    32'(bus.ovf_en),    32'd0);
        check({name, "_illegal"},   32'(bus.illegal),   32'd0);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.instr     = 32'd0;
        bus.rs_val    = 32'd0;
        bus.rt_val    = 32'd0;
        #1 rst = 1'b1;
        #11;
        check_empty_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed decode cases, streaming with out_ready high.
        bus.out_ready = 1'b1;
        send(32'h00221820, 32'd5, 32'd7);
        check_head("add", 32'd5, 32'd7, 3'b001, 1'b1, 1'b0);
        send({6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd3);
        check_head("addi", 32'd10, 32'hFFFF_FFFF, 3'b001, 1'b1, 1'b0);
        send({6'h0c, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd3);
        check_head("andi", 32'd10, 32'h0000_FFFF, 3'b000, 1'b0, 1'b0);
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'h03}, 32'd9, 32'h8000_0000);
        check_head("sra", 32'h8000_0000, 32'd4, 3'b101, 1'b0, 1'b0);
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h06}, 32'h25, 32'h1234);
        check_head("srlv", 32'h1234, 32'd5, 3'b100, 1'b0, 1'b0);
        send({6'h3f, 26'h1234567}, 32'hDEAD, 32'hBEEF);
        check_head("bad_opcode", 32'd0, 32'd0, 3'b111, 1'b0, 1'b1);
        @(posedge clk); #1;

        // Backpressure: two fill the buffer, the third waits, then drain in order.
        bus.out_ready = 1'b0;
        send(32'h00221820, 32'd1, 32'd2);
        send(32'h00221822, 32'd3, 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h0022182a;
        bus.rs_val   = 32'd5;
        bus.rt_val   = 32'd6;
        repeat (3) begin
            @(negedge clk);
            check("held_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'h0022182a, 32'd5, 32'd6);
        repeat (3) @(posedge clk);
        #1;

        // Flush at count 2 with in_valid, then at count 1 with an accepted push.
        bus.out_ready = 1'b0;
        send(32'h00221824, 32'd7, 32'd8);
        send(32'h00221821, 32'd9, 32'd10);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00221820;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush2_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush2_in_ready",  32'(bus.in_ready),  32'd1);
        send(32'h00221820, 32'd11, 32'd12);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00221822;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush1_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset with a full buffer.
        send(32'h00221820, 32'h11, 32'h22);
        send(32'h00221822, 32'h33, 32'h44);
        #2 rst = 1'b1;
        #1;
        check_empty_zero("async_rst");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic with occasional flushes.
        for (int c = 0; c < 1500; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            bus.instr     = rand_instr();
            bus.rs_val    = $urandom();
            bus.rt_val    = $urandom();
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
